// File: rtl/banked_register_file_if.sv
// Bus bundle for banked_register_file.
// Groups the read ports, the two write ports, and the PC, CPSR, SPSR and exception controls.
// The master drives addresses, write data and controls.
// The slave (the register file) returns read data and the PC, CPSR and SPSR views.
interface banked_register_file_if #(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned NUM_READ  = 3
);
    logic [NUM_READ*4-1:0]         rd_addr;
    logic [NUM_READ*WORD_SIZE-1:0] rd_data;

    logic                 w0_we;
    logic [3:0]           w0_addr;
    logic [WORD_SIZE-1:0] w0_data;
    logic                 w1_we;
    logic [3:0]           w1_addr;
    logic [WORD_SIZE-1:0] w1_data;

    logic                 pc_we;
    logic [WORD_SIZE-1:0] pc_in;
    logic                 pc_inc;

    logic                 cpsr_we;
    logic [WORD_SIZE-1:0] cpsr_in;
    logic                 flags_we;
    logic [3:0]           flags_in;
    logic                 spsr_we;
    logic [WORD_SIZE-1:0] spsr_in;
    logic                 spsr_restore;

    logic                 exc_req;
    logic [4:0]           exc_mode;
    logic [WORD_SIZE-1:0] exc_vector;
    logic [WORD_SIZE-1:0] exc_lr;

    logic [WORD_SIZE-1:0] pc_out;
    logic [WORD_SIZE-1:0] cpsr_out;
    logic [WORD_SIZE-1:0] spsr_out;

    modport master (
        output rd_addr, w0_we, w0_addr, w0_data, w1_we, w1_addr, w1_data,
               pc_we, pc_in, pc_inc, cpsr_we, cpsr_in, flags_we, flags_in,
               spsr_we, spsr_in, spsr_restore, exc_req, exc_mode, exc_vector, exc_lr,
        input  rd_data, pc_out, cpsr_out, spsr_out
    );

    modport slave (
        input  rd_addr, w0_we, w0_addr, w0_data, w1_we, w1_addr, w1_data,
               pc_we, pc_in, pc_inc, cpsr_we, cpsr_in, flags_we, flags_in,
               spsr_we, spsr_in, spsr_restore, exc_req, exc_mode, exc_vector, exc_lr,
        output rd_data, pc_out, cpsr_out, spsr_out
    );
endinterface

// File: rtl/banked_register_file.sv
// ARM-style banked register file with PC, CPSR and per-mode SPSRs.
// Ports:
//   clk   - clock; all state updates happen on the rising edge.
//   reset - asynchronous, active-low reset.
//   bus   - banked_register_file_if.slave. It carries:
//           - combinational read ports, where r15 reads return pc + PC_OFFSET;
//           - two write ports, where w0 wins over w1;
//           - PC load and increment;
//           - CPSR, flags and SPSR writes, and SPSR restore;
//           - exception entry;
//           - the pc_out, cpsr_out and spsr_out views.
module banked_register_file #(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned NUM_READ  = 3,
    parameter int unsigned PC_OFFSET = 8,
    parameter int unsigned BYPASS    = 1
) (
    input logic                   clk,
    input logic                   reset,
    banked_register_file_if.slave bus
);
    typedef logic [WORD_SIZE-1:0] word_t;

    // Physical layout:
    //   0-7   r0-r7, shared by all modes
    //   8-12  r8-r12, USR copy
    //   13-17 r8-r12, FIQ copy
    //   18-23 r13, one copy per bank
    //   24-29 r14, one copy per bank
    localparam int unsigned NumPhys = 30;

    localparam logic [2:0] BankUsr = 3'd0;  // also SYS and any invalid mode
    localparam logic [2:0] BankFiq = 3'd1;
    localparam logic [2:0] BankIrq = 3'd2;
    localparam logic [2:0] BankSvc = 3'd3;
    localparam logic [2:0] BankAbt = 3'd4;
    localparam logic [2:0] BankUnd = 3'd5;

    function automatic logic [2:0] mode_bank(input logic [4:0] mode);
        case (mode)
            5'b10001: mode_bank = BankFiq;
            5'b10010: mode_bank = BankIrq;
            5'b10011: mode_bank = BankSvc;
            5'b10111: mode_bank = BankAbt;
            5'b11011: mode_bank = BankUnd;
            default:  mode_bank = BankUsr;
        endcase
    endfunction

    function automatic logic [4:0] phys_idx(input logic [3:0] addr, input logic [2:0] bank);
        if (addr < 4'd8) begin
            phys_idx = 5'(addr);
        end else if (addr <= 4'd12) begin
            phys_idx = (bank == BankFiq) ? 5'(addr) + 5'd5 : 5'(addr);
        end else if (addr == 4'd13) begin
            phys_idx = 5'd18 + 5'(bank);
        end else begin
            phys_idx = 5'd24 + 5'(bank);
        end
    endfunction

    word_t regs_q [NumPhys];
    word_t regs_d [NumPhys];
    word_t spsr_q [1:5];  // indexed by bank; USR/SYS has no SPSR
    word_t spsr_d [1:5];
    word_t pc_q, pc_d;
    word_t cpsr_q, cpsr_d;

    logic [2:0] cur_bank;
    logic [2:0] exc_bank;
    logic       exc_take;

    assign cur_bank = mode_bank(cpsr_q[4:0]);
    assign exc_bank = mode_bank(bus.exc_mode);
    assign exc_take = bus.exc_req && (exc_bank != BankUsr);

    always_comb begin
        regs_d = regs_q;
        spsr_d = spsr_q;
        pc_d   = pc_q;
        cpsr_d = cpsr_q;

        if (exc_take) begin
            spsr_d[exc_bank]                   = cpsr_q;
            regs_d[phys_idx(4'd14, exc_bank)]  = bus.exc_lr;
            cpsr_d[7]                          = 1'b1;
            if (exc_bank == BankFiq) begin
                cpsr_d[6] = 1'b1;
            end
            cpsr_d[4:0]                        = bus.exc_mode;
            pc_d                               = bus.exc_vector;
        end else begin
            // w1 first so that w0 overrides on a shared target.
            if (bus.w1_we && bus.w1_addr != 4'd15) begin
                regs_d[phys_idx(bus.w1_addr, cur_bank)] = bus.w1_data;
            end
            if (bus.w0_we && bus.w0_addr != 4'd15) begin
                regs_d[phys_idx(bus.w0_addr, cur_bank)] = bus.w0_data;
            end

            if (bus.w0_we && bus.w0_addr == 4'd15) begin
                pc_d = bus.w0_data;
            end else if (bus.w1_we && bus.w1_addr == 4'd15) begin
                pc_d = bus.w1_data;
            end else if (bus.pc_we) begin
                pc_d = bus.pc_in;
            end else if (bus.pc_inc) begin
                pc_d = pc_q + word_t'(4);
            end

            // Restore reads the pre-edge SPSR even when spsr_we updates it this cycle.
            if (bus.spsr_restore && cur_bank != BankUsr) begin
                cpsr_d = spsr_q[cur_bank];
            end else if (bus.cpsr_we) begin
                cpsr_d = bus.cpsr_in;
            end else if (bus.flags_we) begin
                cpsr_d[31:28] = bus.flags_in;
            end

            if (bus.spsr_we && cur_bank != BankUsr) begin
                spsr_d[cur_bank] = bus.spsr_in;
            end
        end
    end

    // Forwarding reads regs_d, which already reflects write priority and exception LR writes.
    always_comb begin
        bus.rd_data = '0;
        for (int k = 0; k < NUM_READ; k++) begin
            logic [3:0] ra;
            ra = bus.rd_addr[4*k +: 4];
            if (ra == 4'd15) begin
                bus.rd_data[WORD_SIZE*k +: WORD_SIZE] = pc_q + word_t'(PC_OFFSET);
            end else if (BYPASS != 0) begin
                bus.rd_data[WORD_SIZE*k +: WORD_SIZE] = regs_d[phys_idx(ra, cur_bank)];
            end else begin
                bus.rd_data[WORD_SIZE*k +: WORD_SIZE] = regs_q[phys_idx(ra, cur_bank)];
            end
        end
    end

    assign bus.pc_out   = pc_q;
    assign bus.cpsr_out = cpsr_q;
    assign bus.spsr_out = (cur_bank == BankUsr) ? '0 : spsr_q[cur_bank];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NumPhys; i++) begin
                regs_q[i] <= '0;
            end
            for (int i = 1; i <= 5; i++) begin
                spsr_q[i] <= '0;
            end
            pc_q   <= '0;
            cpsr_q <= word_t'(32'h0000_00D3);
        end else begin
            regs_q <= regs_d;
            spsr_q <= spsr_d;
            pc_q   <= pc_d;
            cpsr_q <= cpsr_d;
        end
    end
endmodule

// File: tb/tb_banked_register_file.sv
// Self-checking bench for banked_register_file.
// The bench runs directed scenarios first, then a randomized run.
// Both are checked against a mode-level reference model.
module tb_banked_register_file;
    localparam logic [4:0] M_USR = 5'h10;
    localparam logic [4:0] M_FIQ = 5'h11;
    localparam logic [4:0] M_IRQ = 5'h12;
    localparam logic [4:0] M_SVC = 5'h13;
    localparam logic [4:0] M_ABT = 5'h17;
    localparam logic [4:0] M_UND = 5'h1B;
    localparam logic [4:0] M_SYS = 5'h1F;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    banked_register_file_if #(.WORD_SIZE(32), .NUM_READ(3)) bus ();

    banked_register_file #(
        .WORD_SIZE(32),
        .NUM_READ (3),
        .PC_OFFSET(8),
        .BYPASS   (1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model, described in terms of what each mode can see.
    logic [31:0] m_user   [15];    // r0-r14 as seen by USR/SYS
    logic [31:0] m_fiq_hi [8:12];  // FIQ's private r8-r12
    logic [31:0] m_sp     [32];    // r13 per privileged mode, indexed by mode number
    logic [31:0] m_lr     [32];
    logic [31:0] m_spsr   [32];
    logic [31:0] m_pc;
    logic [31:0] m_cpsr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [4:0] canon(input logic [4:0] m);
        case (m)
            M_FIQ, M_IRQ, M_SVC, M_ABT, M_UND: return m;
            default: return M_USR;
        endcase
    endfunction

    function automatic logic [31:0] read_reg(input logic [3:0] r, input logic [4:0] c);
        if (r >= 4'd8 && r <= 4'd12 && c == M_FIQ) return m_fiq_hi[r];
        if (r == 4'd13 && c != M_USR) return m_sp[c];
        if (r == 4'd14 && c != M_USR) return m_lr[c];
        return m_user[r];
    endfunction

    task automatic write_reg(input logic [3:0] r, input logic [4:0] c, input logic [31:0] v);
        if (r >= 4'd8 && r <= 4'd12 && c == M_FIQ) m_fiq_hi[r] = v;
        else if (r == 4'd13 && c != M_USR) m_sp[c] = v;
        else if (r == 4'd14 && c != M_USR) m_lr[c] = v;
        else m_user[r] = v;
    endtask

    function automatic logic [31:0] exp_spsr();
        logic [4:0] c;
        c = canon(m_cpsr[4:0]);
        return (c == M_USR) ? 32'h0 : m_spsr[c];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_user[i] = '0;
        for (int i = 8; i <= 12; i++) m_fiq_hi[i] = '0;
        for (int i = 0; i < 32; i++) begin
            m_sp[i] = '0;
            m_lr[i] = '0;
            m_spsr[i] = '0;
        end
        m_pc = '0;
        m_cpsr = 32'hD3;
    endtask

    task automatic model_step();
        logic [31:0] oc;
        logic [4:0]  c, ec;
        oc = m_cpsr;
        c  = canon(oc[4:0]);
        ec = canon(bus.exc_mode);
        if (bus.exc_req && ec != M_USR) begin
            m_spsr[ec] = oc;
            m_lr[ec]   = bus.exc_lr;
            m_cpsr     = {oc[31:8], 1'b1, (ec == M_FIQ) ? 1'b1 : oc[6], oc[5], bus.exc_mode};
            m_pc       = bus.exc_vector;
        end else begin
            if (bus.w0_we && bus.w0_addr == 4'd15) m_pc = bus.w0_data;
            else if (bus.w1_we && bus.w1_addr == 4'd15) m_pc = bus.w1_data;
            else if (bus.pc_we) m_pc = bus.pc_in;
            else if (bus.pc_inc) m_pc = m_pc + 32'd4;
            if (bus.w1_we && bus.w1_addr != 4'd15) write_reg(bus.w1_addr, c, bus.w1_data);
            if (bus.w0_we && bus.w0_addr != 4'd15) write_reg(bus.w0_addr, c, bus.w0_data);
            if (bus.spsr_restore && c != M_USR) m_cpsr = m_spsr[c];
            else if (bus.cpsr_we) m_cpsr = bus.cpsr_in;
            else if (bus.flags_we) m_cpsr = {bus.flags_in, oc[27:0]};
            if (bus.spsr_we && c != M_USR) m_spsr[c] = bus.spsr_in;
        end
    endtask

    task automatic idle();
        bus.rd_addr = '0;
        bus.w0_we = 0; bus.w0_addr = '0; bus.w0_data = '0;
        bus.w1_we = 0; bus.w1_addr = '0; bus.w1_data = '0;
        bus.pc_we = 0; bus.pc_in = '0; bus.pc_inc = 0;
        bus.cpsr_we = 0; bus.cpsr_in = '0; bus.flags_we = 0; bus.flags_in = '0;
        bus.spsr_we = 0; bus.spsr_in = '0; bus.spsr_restore = 0;
        bus.exc_req = 0; bus.exc_mode = '0; bus.exc_vector = '0; bus.exc_lr = '0;
    endtask

    // Called just after a falling edge, with inputs already driven.
    // Checks the pre-edge outputs, including forwarded reads, then advances one cycle.
    task automatic tick();
        logic [31:0] old_pc, old_cpsr, old_spsr, exp;
        logic [4:0]  oc;
        logic [3:0]  ra;
        #1;
        old_pc   = m_pc;
        old_cpsr = m_cpsr;
        old_spsr = exp_spsr();
        oc       = canon(m_cpsr[4:0]);
        check("pc_out", bus.pc_out, old_pc);
        check("cpsr_out", bus.cpsr_out, old_cpsr);
        check("spsr_out", bus.spsr_out, old_spsr);
        model_step();
        for (int k = 0; k < 3; k++) begin
            ra  = bus.rd_addr[4*k +: 4];
            exp = (ra == 4'd15) ? old_pc + 32'd8 : read_reg(ra, oc);
            check($sformatf("rd%0d_r%0d", k, ra), bus.rd_data[32*k +: 32], exp);
        end
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    function automatic logic [4:0] pick_mode();
        logic [4:0] modes [9];
        modes = '{M_USR, M_FIQ, M_IRQ, M_SVC, M_ABT, M_UND, M_SYS, 5'h00, 5'h15};
        return modes[$urandom_range(8, 0)];
    endfunction

    task automatic randomize_inputs();
        bus.rd_addr = 12'($urandom);
        bus.w0_we = ($urandom_range(1, 0) == 1); bus.w0_addr = 4'($urandom);
        bus.w0_data = $urandom;
        bus.w1_we = ($urandom_range(9, 0) < 4);
        bus.w1_addr = ($urandom_range(3, 0) == 0) ? bus.w0_addr : 4'($urandom);
        bus.w1_data = $urandom;
        bus.pc_we = ($urandom_range(4, 0) == 0); bus.pc_in = $urandom;
        bus.pc_inc = ($urandom_range(1, 0) == 1);
        bus.cpsr_we = ($urandom_range(6, 0) == 0);
        bus.cpsr_in = {24'($urandom), 3'($urandom), pick_mode()};
        bus.flags_we = ($urandom_range(4, 0) == 0); bus.flags_in = 4'($urandom);
        bus.spsr_we = ($urandom_range(4, 0) == 0);
        bus.spsr_in = {24'($urandom), 3'($urandom), pick_mode()};
        bus.spsr_restore = ($urandom_range(9, 0) == 0);
        bus.exc_req = ($urandom_range(11, 0) == 0); bus.exc_mode = pick_mode();
        bus.exc_vector = $urandom; bus.exc_lr = $urandom;
    endtask

    initial begin
        idle();
        model_reset();
        bus.rd_addr = 12'h00F;
        repeat (2) @(negedge clk);
        #1;
        check("rst_cpsr", bus.cpsr_out, 32'hD3);
        check("rst_pc", bus.pc_out, 32'h0);
        check("rst_r15", bus.rd_data[31:0], 32'h8);
        @(negedge clk);
        reset = 1'b1;

        // Idle after reset release.
        bus.rd_addr = 12'h00F;
        tick();
        check("idle_cpsr", bus.cpsr_out, 32'hD3);
        check("idle_pc", bus.pc_out, 32'h0);

        // r13 banking between SVC and USR.
        bus.w0_we = 1; bus.w0_addr = 4'd13; bus.w0_data = 32'h1000; tick();
        bus.cpsr_we = 1; bus.cpsr_in = 32'h10; tick();
        bus.w0_we = 1; bus.w0_addr = 4'd13; bus.w0_data = 32'h2000; tick();
        bus.cpsr_we = 1; bus.cpsr_in = 32'hD3; tick();
        bus.rd_addr = 12'h00D; #1;
        check("r13_svc", bus.rd_data[31:0], 32'h1000);
        bus.cpsr_we = 1; bus.cpsr_in = 32'h10; tick();
        bus.rd_addr = 12'h00D; #1;
        check("r13_usr", bus.rd_data[31:0], 32'h2000);

        // FIQ entry from USR drops the same-cycle w0 write.
        bus.exc_req = 1; bus.exc_mode = M_FIQ; bus.exc_vector = 32'h1C; bus.exc_lr = 32'h104;
        bus.w0_we = 1; bus.w0_addr = 4'd0; bus.w0_data = 32'h55;
        tick();
        check("exc_cpsr", bus.cpsr_out, 32'hD1);
        check("exc_spsr", bus.spsr_out, 32'h10);
        check("exc_pc", bus.pc_out, 32'h1C);
        bus.rd_addr = 12'h00E; #1;
        check("exc_lr", bus.rd_data[31:0], 32'h104);
        check("exc_r0", bus.rd_data[95:64], 32'h0);

        // w0 beats w1 on r3, both forwarded and registered.
        bus.w0_we = 1; bus.w0_addr = 4'd3; bus.w0_data = 32'hA;
        bus.w1_we = 1; bus.w1_addr = 4'd3; bus.w1_data = 32'hB;
        bus.rd_addr = 12'h030; #1;
        check("fwd_r3", bus.rd_data[63:32], 32'hA);
        tick();
        bus.rd_addr = 12'h030; #1;
        check("reg_r3", bus.rd_data[63:32], 32'hA);

        // PC wrap and priority.
        bus.pc_we = 1; bus.pc_in = 32'hFFFF_FFFC; tick();
        bus.pc_inc = 1; tick();
        check("pc_wrap", bus.pc_out, 32'h0);
        bus.pc_we = 1; bus.pc_in = 32'h40; bus.pc_inc = 1; tick();
        check("pc_we_inc", bus.pc_out, 32'h40);
        bus.w0_we = 1; bus.w0_addr = 4'd15; bus.w0_data = 32'h80;
        bus.pc_we = 1; bus.pc_in = 32'h100; tick();
        check("pc_w0", bus.pc_out, 32'h80);

        // IRQ SPSR restore beats flags_we; the mode drops to SYS.
        bus.cpsr_we = 1; bus.cpsr_in = 32'hD2; tick();
        bus.w0_we = 1; bus.w0_addr = 4'd13; bus.w0_data = 32'h3333; tick();
        bus.spsr_we = 1; bus.spsr_in = 32'h6000_001F; tick();
        check("irq_spsr", bus.spsr_out, 32'h6000_001F);
        bus.spsr_restore = 1; bus.flags_we = 1; bus.flags_in = 4'h9; tick();
        check("restore_cpsr", bus.cpsr_out, 32'h6000_001F);
        check("sys_spsr", bus.spsr_out, 32'h0);
        bus.rd_addr = 12'h00D; #1;
        check("sys_r13", bus.rd_data[31:0], 32'h2000);

        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            tick();
        end

        // Asynchronous reset while writes and an exception are pending.
        randomize_inputs();
        bus.exc_req = 1; bus.exc_mode = M_ABT;
        bus.rd_addr = 12'h00F;
        reset = 1'b0;
        #1;
        check("arst_pc", bus.pc_out, 32'h0);
        check("arst_cpsr", bus.cpsr_out, 32'hD3);
        check("arst_r15", bus.rd_data[31:0], 32'h8);
        @(posedge clk);
        @(negedge clk);
        idle();
        model_reset();
        reset = 1'b1;
        bus.rd_addr = 12'h0FF;
        tick();

        for (int i = 0; i < 150; i++) begin
            randomize_inputs();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/banked_register_file.md
BANKED_REGISTER_FILE -- requirements
Module: banked_register_file

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32: register/data width in bits (min 32).
REQ-002 SHALL have parameter NUM_READ, default 3: number of read ports.
REQ-003 SHALL have parameter PC_OFFSET, default 8: value added to the PC when r15 is read through a read port.
REQ-004 SHALL have parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset; state cleared while reset==0.
REQ-007 rd_addr  in  NUM_READ*4  read addresses; port k uses bits [4k+3:4k].
REQ-008 rd_data  out  NUM_READ*WORD_SIZE  read data; port k uses slice k.
REQ-009 w0_we, w0_addr, w0_data  in  1/4/WORD_SIZE  primary (ALU result) write port.
REQ-010 w1_we, w1_addr, w1_data  in  1/4/WORD_SIZE  secondary (base writeback) write port.
REQ-011 pc_we, pc_in  in  1/WORD_SIZE  direct PC load.
REQ-012 pc_inc  in  1  advance PC by 4.
REQ-013 cpsr_we, cpsr_in  in  1/WORD_SIZE  full CPSR write.
REQ-014 flags_we, flags_in  in  1/4  NZCV-only write to CPSR[31:28].
REQ-015 spsr_we, spsr_in  in  1/WORD_SIZE  write SPSR of the current mode.
REQ-016 spsr_restore  in  1  copy the current mode's SPSR into the CPSR.
REQ-017 exc_req, exc_mode, exc_vector, exc_lr  in  1/5/WORD_SIZE/WORD_SIZE  exception entry.
REQ-018 pc_out, cpsr_out, spsr_out  out  WORD_SIZE each  current PC, CPSR, and current-mode SPSR.

Function
REQ-019 Mode SHALL be CPSR[4:0]: USR 10000, FIQ 10001, IRQ 10010, SVC 10011, ABT 10111, UND 11011, SYS 11111; any other value SHALL select the USR bank.
REQ-020 Physical storage SHALL be: r0-r7 shared; r8-r12 split into USR and FIQ copies; r13-r14 split into USR/SYS, FIQ, IRQ, SVC, ABT and UND copies; a single r15; one SPSR each for FIQ, IRQ, SVC, ABT and UND.
REQ-021 Reads SHALL be combinational and resolve the bank from the current CPSR mode; reading r15 SHALL return pc + PC_OFFSET, modulo 2^WORD_SIZE.
REQ-022 With BYPASS=1, a read of a register written this cycle SHALL return the value that register takes at the next edge, obeying REQ-024 priority; r15 reads are never forwarded.
REQ-023 Writes through w0/w1 SHALL go to the bank selected by the pre-edge mode.
REQ-024 If w0 and w1 target the same register in the same cycle, w0 SHALL win.
REQ-025 PC next-value priority SHALL be: exc_req > w0 to r15 > w1 to r15 > pc_we > pc_inc (pc+4, wrapping); otherwise the PC holds.
REQ-026 CPSR priority SHALL be: exc_req > spsr_restore > cpsr_we > flags_we.
REQ-027 With exc_req=1 in one cycle, the block SHALL:
  - write SPSR[exc_mode] <= CPSR;
  - write LR[exc_mode] <= exc_lr;
  - set CPSR[4:0] <= exc_mode and CPSR[7] (I) <= 1;
  - set CPSR[6] (F) <= 1 only if exc_mode is FIQ;
  - set PC <= exc_vector;
  - ignore w0, w1, pc_we, pc_inc, cpsr_we, flags_we, spsr_we and spsr_restore that cycle.
REQ-028 exc_req with exc_mode USR, SYS or invalid SHALL be ignored entirely, and the other inputs SHALL act normally.
REQ-029 spsr_out SHALL read 0 in USR/SYS/invalid mode; in those modes spsr_we and spsr_restore SHALL be ignored.
REQ-030 spsr_we together with spsr_restore SHALL restore the old SPSR value while the SPSR is updated.
REQ-031 A mode change SHALL take effect for reads and writes from the cycle after the edge that updates the CPSR.

Reset
REQ-032 While reset==0, the block SHALL hold all general registers, banked copies, SPSRs and the PC at 0, and CPSR at 0x000000D3 (SVC, I=F=1).
REQ-033 Reset SHALL abort any same-cycle write or exception with no partial update; the first edge after reset rises SHALL operate normally.

Verification
REQ-034 Release reset, idle -> cpsr_out=0xD3, pc_out=0, rd_data port0 with addr 15 = 8.
REQ-035 In SVC write r13=0x1000; cpsr_we with mode USR; write r13=0x2000; cpsr_we back to SVC; read r13 -> 0x1000, and in USR r13 -> 0x2000.
REQ-036 exc_req mode FIQ, vector 0x1C, lr 0x104, CPSR=0x10 -> CPSR=0xD1, SPSR_fiq=0x10, r14_fiq=0x104, pc=0x1C; the same-cycle w0 write to r0 is dropped.
REQ-037 w0 and w1 both write r3 (0xA, 0xB) with BYPASS=1 -> same-cycle read of r3 = 0xA, registered r3 = 0xA.
REQ-038 pc=0xFFFFFFFC with pc_inc -> pc=0; pc_we=0x40 with pc_inc -> pc=0x40; w0 to r15 0x80 with pc_we -> pc=0x80.
REQ-039 In IRQ with SPSR_irq=0x6000001F, spsr_restore with flags_we -> CPSR=0x6000001F, and r13 reads the USR/SYS copy next cycle.
